// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bcd_pkg
//  Description : Shared constants for the sequential BCD-to-binary converter:
//                FSM state encodings, digit adjust constants, clog2 helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_pkg;

    // FSM state encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Largest legal decimal digit
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    // Reverse double-dabble: digits >= 8 after a right shift get 3 removed
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

    // Number of bits needed to hold values 0 .. value-1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Single-digit correction for reverse double-dabble. After the
//                right shift a digit holding 8 or more carried half of a ten
//                down from its neighbour; subtracting 3 restores it to BCD.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Subtract 3 from any digit at or above the threshold
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit - ADJ_SUB) : i_digit;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2bin_seq
//  Description : Sequential BCD-to-binary converter (reverse double-dabble).
//                Accepts DIGITS packed BCD digits plus a sign and produces a
//                two's-complement WORD_LENGTH result with ready/error flags.
//                One shift iteration per clock, one extra clock to finalise.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int WORD_LENGTH = 16,
    parameter int DIGITS      = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*DIGITS-1:0]    bcd_in,
    input  logic                   sign_in,
    output logic [WORD_LENGTH-1:0] bin,
    output logic                   busy,
    output logic                   ready,
    output logic                   error
);

    localparam int C_MAG_W = 4 * DIGITS;
    localparam int C_CNT_W = clog2(C_MAG_W + 1);
    localparam int C_EXT_W = ((C_MAG_W > WORD_LENGTH) ? C_MAG_W : WORD_LENGTH) + 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_MAG_W);

    logic [1:0]             r_state;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [C_MAG_W-1:0]     r_bcd;
    logic [C_MAG_W-1:0]     r_mag;
    logic                   r_sign;
    logic [WORD_LENGTH-1:0] r_bin;
    logic                   r_busy;
    logic                   r_ready;
    logic                   r_error;

    logic [C_MAG_W-1:0]     w_bcd_shift;
    logic [C_MAG_W-1:0]     w_mag_shift;
    logic [C_MAG_W-1:0]     w_bcd_adj;
    logic                   w_bad_digit;
    logic                   w_accept;
    logic [C_EXT_W-1:0]     w_mag_ext;
    logic [C_EXT_W-1:0]     w_limit;
    logic                   w_overflow;
    logic [WORD_LENGTH-1:0] w_mag_word;
    logic [WORD_LENGTH-1:0] w_result;

    // The {bcd, mag} pair shifts right as one long register
    assign w_bcd_shift = {1'b0, r_bcd[C_MAG_W-1:1]};
    assign w_mag_shift = {r_bcd[0], r_mag[C_MAG_W-1:1]};

    // One digit corrector per BCD digit on the shifted value
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (w_bcd_shift[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    // Flag any input digit outside 0..9
    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > DIGIT_MAX) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    // start only counts when no conversion is running
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Overflow compare done wide enough that neither side truncates
    assign w_mag_ext  = C_EXT_W'(r_mag);
    assign w_limit    = (C_EXT_W'(1) << (WORD_LENGTH - 1)) - C_EXT_W'(1);
    assign w_overflow = (w_mag_ext > w_limit);
    assign w_mag_word = WORD_LENGTH'(r_mag);
    // Negating zero yields zero, so no negative-zero special case is needed
    assign w_result   = r_sign ? (-w_mag_word) : w_mag_word;

    // FSM, shift datapath and registered output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_mag   <= '0;
            r_sign  <= 1'b0;
            r_bin   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_bad_digit) begin
                            r_state <= S_DONE;
                            r_bin   <= '0;
                            r_error <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_SHIFT;
                            r_bcd   <= bcd_in;
                            r_mag   <= '0;
                            r_sign  <= sign_in;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                            r_error <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == C_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        if (w_overflow) begin
                            r_error <= 1'b1;
                            r_bin   <= '0;
                        end else begin
                            r_error <= 1'b0;
                            r_bin   <= w_result;
                        end
                    end else begin
                        r_bcd <= w_bcd_adj;
                        r_mag <= w_mag_shift;
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bin   = r_bin;
    assign busy  = r_busy;
    assign ready = r_ready;
    assign error = r_error;

endmodule : bcd2bin_seq
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd2bin_seq
//  Description : Directed self-checking bench for bcd2bin_seq, with a 16-bit
//                and an 8-bit result instance sharing clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd2bin_seq;

    logic        clk;
    logic        reset;
    logic        start16, start8;
    logic [11:0] bcd16, bcd8;
    logic        sign16, sign8;
    logic [15:0] bin16;
    logic [7:0]  bin8;
    logic        busy16, ready16, error16;
    logic        busy8, ready8, error8;

    int n_total;
    int n_bad;

    bcd2bin_seq #(.WORD_LENGTH(16), .DIGITS(3)) u_dut16 (
        .clk     (clk),
        .reset   (reset),
        .start   (start16),
        .bcd_in  (bcd16),
        .sign_in (sign16),
        .bin     (bin16),
        .busy    (busy16),
        .ready   (ready16),
        .error   (error16)
    );

    bcd2bin_seq #(.WORD_LENGTH(8), .DIGITS(3)) u_dut8 (
        .clk     (clk),
        .reset   (reset),
        .start   (start8),
        .bcd_in  (bcd8),
        .sign_in (sign8),
        .bin     (bin8),
        .busy    (busy8),
        .ready   (ready8),
        .error   (error8)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pulse start for one clock on the selected instance; returns just after the accept edge
    task automatic pulse(input bit sel8, input logic [11:0] b, input logic s);
        @(negedge clk);
        if (sel8) begin
            bcd8 = b; sign8 = s; start8 = 1'b1;
        end else begin
            bcd16 = b; sign16 = s; start16 = 1'b1;
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // Count edges until ready rises, bounded
    task automatic wait_ready(input bit sel8, output int n);
        n = 0;
        while (!(sel8 ? ready8 : ready16) && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    int lat;

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1;
        start16 = 1'b0; start8 = 1'b0;
        bcd16 = '0; bcd8 = '0; sign16 = 1'b0; sign8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst_bin",   bin16, 16'h0000);
        check_val("rst_flags", {13'd0, busy16, ready16, error16}, 16'h0000);

        // 123 positive
        pulse(1'b0, 12'h123, 1'b0);
        check_val("123_busy_rdy", {14'd0, busy16, ready16}, 16'h0002);
        wait_ready(1'b0, lat);
        check_val("123_latency", 16'(lat), 16'd13);
        check_val("123_bin", bin16, 16'h007B);
        check_val("123_flags", {13'd0, busy16, ready16, error16}, 16'h0002);

        // -999
        pulse(1'b0, 12'h999, 1'b1);
        check_val("999_rdy_drop", {15'd0, ready16}, 16'h0000);
        check_val("999_bin_hold", bin16, 16'h007B);
        wait_ready(1'b0, lat);
        check_val("999_latency", 16'(lat), 16'd13);
        check_val("999_bin", bin16, 16'hFC19);
        check_val("999_err", {15'd0, error16}, 16'h0000);

        // No negative zero, then 1
        pulse(1'b0, 12'h000, 1'b1);
        wait_ready(1'b0, lat);
        check_val("neg0_bin", bin16, 16'h0000);
        check_val("neg0_err", {15'd0, error16}, 16'h0000);
        pulse(1'b0, 12'h001, 1'b0);
        wait_ready(1'b0, lat);
        check_val("one_bin", bin16, 16'h0001);

        // Bad digit: immediate error, never busy
        pulse(1'b0, 12'h1A5, 1'b0);
        check_val("bad_flags", {13'd0, busy16, ready16, error16}, 16'h0003);
        check_val("bad_bin", bin16, 16'h0000);
        @(negedge clk);
        check_val("bad_busy_later", {15'd0, busy16}, 16'h0000);

        // Start while busy is ignored
        pulse(1'b0, 12'h456, 1'b0);
        repeat (3) @(negedge clk);
        pulse(1'b0, 12'h789, 1'b0);
        wait_ready(1'b0, lat);
        check_val("ign_latency", 16'(lat + 5), 16'd13);
        check_val("ign_bin", bin16, 16'h01C8);
        check_val("ign_err", {15'd0, error16}, 16'h0000);

        // Reset mid-conversion
        pulse(1'b0, 12'h321, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("midrst_bin", bin16, 16'h0000);
        check_val("midrst_flags", {13'd0, busy16, ready16, error16}, 16'h0000);
        repeat (20) @(negedge clk);
        check_val("midrst_idle", {14'd0, busy16, ready16}, 16'h0000);
        pulse(1'b0, 12'h050, 1'b0);
        wait_ready(1'b0, lat);
        check_val("050_latency", 16'(lat), 16'd13);
        check_val("050_bin", bin16, 16'h0032);

        // 8-bit instance: overflow and boundaries
        pulse(1'b1, 12'h200, 1'b0);
        wait_ready(1'b1, lat);
        check_val("w8_200_err", {15'd0, error8}, 16'h0001);
        check_val("w8_200_bin", {8'd0, bin8}, 16'h0000);
        pulse(1'b1, 12'h127, 1'b0);
        wait_ready(1'b1, lat);
        check_val("w8_127_bin", {8'd0, bin8}, 16'h007F);
        check_val("w8_127_err", {15'd0, error8}, 16'h0000);
        pulse(1'b1, 12'h127, 1'b1);
        wait_ready(1'b1, lat);
        check_val("w8_m127_bin", {8'd0, bin8}, 16'h0081);
        pulse(1'b1, 12'h128, 1'b1);
        wait_ready(1'b1, lat);
        check_val("w8_m128_err", {15'd0, error8}, 16'h0001);
        check_val("w8_m128_bin", {8'd0, bin8}, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_bcd2bin_seq
`default_nettype wire
